pixel_raster_writer: RTL and testbench

PIXEL_RASTER_WRITER -- requirements
Module: pixel_raster_writer

---
 rtl/jpeg_pkg.sv | 25 ++
 rtl/sync_fifo.sv | 65 ++++++
 rtl/pixel_raster_writer.sv | 191 +++++++++++++++++++
 tb/tb_pixel_raster_writer.sv | 394 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jpeg_pkg.sv
//------------------------------------------------------------------------------
// jpeg_pkg
//   Shared types and constants for the JPEG decoder back end: raster-writer
//   FSM state encoding and MCU geometry.
//   Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package jpeg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int MCU_DIM_444 = 8;
    localparam int MCU_DIM_420 = 16;
    localparam int MCU_PIX_444 = 64;
    localparam int MCU_PIX_420 = 256;

endpackage

`default_nettype wire

// File: rtl/sync_fifo.sv
//------------------------------------------------------------------------------
// sync_fifo
//   Single-clock FIFO with registered occupancy count, first-word fall-through
//   read port and synchronous flush. Pushes while full are discarded.
//   Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module sync_fifo #(
    parameter int WIDTH = 44,
    parameter int DEPTH = 256
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    input  logic                       pop,
    output logic [WIDTH-1:0]           dout,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty,
    output logic                       full
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic               w_do_push;
    logic               w_do_pop;

    assign empty     = (r_count == '0);
    assign full      = (r_count == c_CNT_W'(DEPTH));
    assign count     = r_count;
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;
    // Zero when empty so the write port shows a clean bus after reset/flush.
    assign dout      = empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= din;
    end

endmodule

`default_nettype wire

// File: rtl/pixel_raster_writer.sv
//------------------------------------------------------------------------------
// pixel_raster_writer
//   Converts MCU-ordered pixels to linear frame-buffer writes with edge
//   clipping and a buffering FIFO. Define PIXEL_RASTER_RGB565_EN for RGB565
//   write data; otherwise RGB888.
//   Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module pixel_raster_writer
    import jpeg_pkg::*;
#(
    parameter int ADDR_W     = 20,
    parameter int FIFO_DEPTH = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              frame_start,
    input  logic              mode_420,
    input  logic [15:0]       img_width,
    input  logic [15:0]       img_height,
    input  logic [7:0]        r_in,
    input  logic [7:0]        g_in,
    input  logic [7:0]        b_in,
    input  logic              pixel_valid,
    output logic              space_ok,
    output logic              wr_valid,
    input  logic              wr_ready,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [23:0]       wr_data,
    output logic              frame_done,
    output logic              overflow_err,
    output logic              protocol_err
);

    localparam int c_CNT_W   = $clog2(FIFO_DEPTH) + 1;
    localparam int c_ENTRY_W = ADDR_W + 24;

    state_t        r_state;
    logic          r_mode_420;
    logic [15:0]   r_width;
    logic [15:0]   r_height;
    logic [15:0]   r_mcu_x;
    logic [15:0]   r_mcu_y;
    logic [15:0]   r_mcu_x_last;
    logic [15:0]   r_mcu_y_last;
    logic [3:0]    r_col;
    logic [3:0]    r_row;
    logic          r_frame_done;
    logic          r_overflow_err;
    logic          r_protocol_err;

    logic [3:0]           w_dim_last;
    logic [31:0]          w_x;
    logic [31:0]          w_y;
    logic                 w_in_bounds;
    logic [ADDR_W-1:0]    w_pix_addr;
    logic [23:0]          w_pix_data;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_flush;
    logic                 w_geom_zero;
    logic [c_ENTRY_W-1:0] w_dout;
    logic [c_CNT_W-1:0]   w_count;
    logic [c_CNT_W-1:0]   w_free;
    logic                 w_empty;
    logic                 w_full;

    assign w_dim_last  = r_mode_420 ? 4'(MCU_DIM_420 - 1) : 4'(MCU_DIM_444 - 1);
    assign w_x = r_mode_420 ? (({16'd0, r_mcu_x} << 4) + {28'd0, r_col})
                            : (({16'd0, r_mcu_x} << 3) + {28'd0, r_col});
    assign w_y = r_mode_420 ? (({16'd0, r_mcu_y} << 4) + {28'd0, r_row})
                            : (({16'd0, r_mcu_y} << 3) + {28'd0, r_row});
    assign w_in_bounds = (w_x < {16'd0, r_width}) && (w_y < {16'd0, r_height});
    assign w_pix_addr  = ADDR_W'(w_y * {16'd0, r_width} + w_x);

`ifdef PIXEL_RASTER_RGB565_EN
    assign w_pix_data = {8'h00, r_in[7:3], g_in[7:2], b_in[7:3]};
`else
    assign w_pix_data = {r_in, g_in, b_in};
`endif

    assign w_geom_zero = (img_width == 16'd0) || (img_height == 16'd0);
    assign w_flush     = frame_start && ((r_state == ST_RUN) || (r_state == ST_DRAIN));
    assign w_push      = (r_state == ST_RUN) && pixel_valid && !frame_start && w_in_bounds;
    assign w_pop       = !w_empty && wr_ready;

    sync_fifo #(
        .WIDTH (c_ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (w_flush),
        .push  (w_push),
        .din   ({w_pix_addr, w_pix_data}),
        .pop   (w_pop),
        .dout  (w_dout),
        .count (w_count),
        .empty (w_empty),
        .full  (w_full)
    );

    assign w_free       = c_CNT_W'(FIFO_DEPTH) - w_count;
    assign space_ok     = w_free >= (r_mode_420 ? c_CNT_W'(MCU_PIX_420) : c_CNT_W'(MCU_PIX_444));
    assign wr_valid     = !w_empty;
    assign wr_addr      = w_dout[c_ENTRY_W-1 -: ADDR_W];
    assign wr_data      = w_dout[23:0];
    assign frame_done   = r_frame_done;
    assign overflow_err = r_overflow_err;
    assign protocol_err = r_protocol_err;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state        <= ST_IDLE;
            r_mode_420     <= 1'b0;
            r_width        <= '0;
            r_height       <= '0;
            r_mcu_x        <= '0;
            r_mcu_y        <= '0;
            r_mcu_x_last   <= '0;
            r_mcu_y_last   <= '0;
            r_col          <= '0;
            r_row          <= '0;
            r_frame_done   <= 1'b0;
            r_overflow_err <= 1'b0;
            r_protocol_err <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            if (pixel_valid && (r_state != ST_RUN)) r_protocol_err <= 1'b1;
            // Registered-count full check: a same-cycle pop does not rescue the pixel.
            if (w_push && w_full) r_overflow_err <= 1'b1;

            if (frame_start && (r_state != ST_DONE)) begin
                r_mode_420   <= mode_420;
                r_width      <= img_width;
                r_height     <= img_height;
                r_mcu_x      <= '0;
                r_mcu_y      <= '0;
                r_col        <= '0;
                r_row        <= '0;
                r_mcu_x_last <= mode_420 ? ((img_width - 16'd1) >> 4) : ((img_width - 16'd1) >> 3);
                r_mcu_y_last <= mode_420 ? ((img_height - 16'd1) >> 4) : ((img_height - 16'd1) >> 3);
                if (w_geom_zero) begin
                    r_state      <= ST_DONE;
                    r_frame_done <= 1'b1;
                end else begin
                    r_state <= ST_RUN;
                end
            end else begin
                case (r_state)
                    ST_RUN: begin
                        if (pixel_valid) begin
                            if (r_col != w_dim_last) begin
                                r_col <= r_col + 4'd1;
                            end else begin
                                r_col <= '0;
                                if (r_row != w_dim_last) begin
                                    r_row <= r_row + 4'd1;
                                end else begin
                                    r_row <= '0;
                                    if (r_mcu_x != r_mcu_x_last) begin
                                        r_mcu_x <= r_mcu_x + 16'd1;
                                    end else begin
                                        r_mcu_x <= '0;
                                        if (r_mcu_y != r_mcu_y_last) begin
                                            r_mcu_y <= r_mcu_y + 16'd1;
                                        end else begin
                                            r_state <= ST_DRAIN;
                                        end
                                    end
                                end
                            end
                        end
                    end
                    ST_DRAIN: begin
                        if (w_empty) begin
                            r_state      <= ST_DONE;
                            r_frame_done <= 1'b1;
                        end
                    end
                    ST_DONE: r_state <= ST_IDLE;
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_pixel_raster_writer.sv
//------------------------------------------------------------------------------
// tb_pixel_raster_writer
//   Directed self-checking bench for pixel_raster_writer.
//   Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_pixel_raster_writer;

    localparam int ADDR_W = 20;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              frame_start;
    logic              mode_420;
    logic [15:0]       img_width;
    logic [15:0]       img_height;
    logic [7:0]        r_in;
    logic [7:0]        g_in;
    logic [7:0]        b_in;
    logic              pixel_valid;
    logic              space_ok;
    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [23:0]       wr_data;
    logic              frame_done;
    logic              overflow_err;
    logic              protocol_err;

    int n_checks = 0;
    int n_fail   = 0;
    logic [ADDR_W+23:0] wq [$];
    int fd_cnt = 0;

    always #5 clk = ~clk;

    pixel_raster_writer #(.ADDR_W(ADDR_W), .FIFO_DEPTH(256)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .frame_start  (frame_start),
        .mode_420     (mode_420),
        .img_width    (img_width),
        .img_height   (img_height),
        .r_in         (r_in),
        .g_in         (g_in),
        .b_in         (b_in),
        .pixel_valid  (pixel_valid),
        .space_ok     (space_ok),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .frame_done   (frame_done),
        .overflow_err (overflow_err),
        .protocol_err (protocol_err)
    );

    // Capture of completed write transfers and frame_done pulses.
    always @(negedge clk) begin
        if (rst_n) begin
            if (wr_valid && wr_ready) wq.push_back({wr_addr, wr_data});
            if (frame_done) fd_cnt++;
        end
    end

    function automatic logic [23:0] pix(input int n);
        logic [15:0] v;
        v = n[15:0];
        return {v[7:0], v[15:8] ^ 8'h3C, ~v[7:0] ^ v[11:4]};
    endfunction

    function automatic logic [23:0] exp_data(input logic [23:0] p);
`ifdef PIXEL_RASTER_RGB565_EN
        return {8'h00, p[23:19], p[15:10], p[7:3]};
`else
        return p;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; frame_start = 1'b0; pixel_valid = 1'b0; wr_ready = 1'b0;
        mode_420 = 1'b0; img_width = '0; img_height = '0;
        r_in = '0; g_in = '0; b_in = '0;
        tick(); tick();
        rst_n = 1'b1;
        wq.delete();
        fd_cnt = 0;
    endtask

    task automatic start_frame(input logic m, input logic [15:0] w, input logic [15:0] h);
        frame_start = 1'b1; mode_420 = m; img_width = w; img_height = h;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic send_pixel(input int n);
        {r_in, g_in, b_in} = pix(n);
        pixel_valid = 1'b1;
        tick();
        pixel_valid = 1'b0;
    endtask

    task automatic wait_frame(input int budget, output bit ok);
        for (int i = 0; i < budget && fd_cnt == 0; i++) tick();
        ok = (fd_cnt != 0);
        repeat (3) tick();
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (wr_valid !== 1'b0 || frame_done !== 1'b0 || overflow_err !== 1'b0 || protocol_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got wv=%b fd=%b ov=%b pe=%b, want all 0", wr_valid, frame_done, overflow_err, protocol_err);
        end
        n_checks++;
        if (space_ok !== 1'b1 || wr_addr !== '0 || wr_data !== '0) begin
            n_fail++;
            $display("FAIL reset_bus: got space_ok=%b addr=%h data=%h, want 1/0/0", space_ok, wr_addr, wr_data);
        end
    endtask

    task automatic test_protocol();
        do_reset();
        wr_ready = 1'b1;
        send_pixel(5);
        n_checks++;
        if (protocol_err !== 1'b1 || wr_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_pixel: got pe=%b wv=%b, want 1/0", protocol_err, wr_valid);
        end
        repeat (3) tick();
        n_checks++;
        if (wq.size() != 0) begin
            n_fail++;
            $display("FAIL idle_no_write: got %0d writes, want 0", wq.size());
        end
        start_frame(1'b0, 16'd0, 16'd8);
        n_checks++;
        if (frame_done !== 1'b1) begin
            n_fail++;
            $display("FAIL zero_geom_done: got frame_done=%b, want 1", frame_done);
        end
        tick();
        n_checks++;
        if (frame_done !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_geom_pulse: got frame_done=%b, want 0", frame_done);
        end
    endtask

    task automatic test_444_frame();
        bit ok;
        int bad;
        do_reset();
        wr_ready = 1'b1;
        start_frame(1'b0, 16'd8, 16'd8);
        send_pixel(0);
        n_checks++;
        if (wr_valid !== 1'b1 || wr_addr !== '0 || wr_data !== exp_data(pix(0))) begin
            n_fail++;
            $display("FAIL latency: got wv=%b addr=%h data=%h, want 1/0/%h", wr_valid, wr_addr, wr_data, exp_data(pix(0)));
        end
        for (int n = 1; n < 64; n++) send_pixel(n);
        wait_frame(200, ok);
        n_checks++;
        if (!ok || fd_cnt != 1) begin
            n_fail++;
            $display("FAIL 444_frame_done: got %0d pulses, want 1", fd_cnt);
        end
        n_checks++;
        if (wq.size() != 64) begin
            n_fail++;
            $display("FAIL 444_count: got %0d writes, want 64", wq.size());
        end
        bad = 0;
        for (int i = 0; i < wq.size() && i < 64; i++)
            if (wq[i] !== {ADDR_W'(i), exp_data(pix(i))}) bad++;
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL 444_order: got %0d bad entries, want 0", bad);
        end
    endtask

    task automatic test_420_clip();
        bit ok;
        int bad, n, x, y;
        logic [ADDR_W+23:0] exp_q [$];
        do_reset();
        wr_ready = 1'b1;
        start_frame(1'b1, 16'd20, 16'd10);
        n = 0;
        for (int mx = 0; mx < 2; mx++)
            for (int row = 0; row < 16; row++)
                for (int col = 0; col < 16; col++) begin
                    send_pixel(n);
                    x = mx * 16 + col;
                    y = row;
                    if (x < 20 && y < 10) exp_q.push_back({ADDR_W'(y * 20 + x), exp_data(pix(n))});
                    n++;
                end
        wait_frame(400, ok);
        n_checks++;
        if (!ok || fd_cnt != 1) begin
            n_fail++;
            $display("FAIL 420_frame_done: got %0d pulses, want 1", fd_cnt);
        end
        n_checks++;
        if (wq.size() != 200) begin
            n_fail++;
            $display("FAIL 420_count: got %0d writes, want 200", wq.size());
        end
        bad = 0;
        for (int i = 0; i < wq.size() && i < exp_q.size(); i++)
            if (wq[i] !== exp_q[i]) bad++;
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL 420_entries: got %0d bad entries, want 0", bad);
        end
        n_checks++;
        if (wq.size() == 0 || wq[wq.size()-1][ADDR_W+23:24] !== ADDR_W'(199)) begin
            n_fail++;
            $display("FAIL 420_last_addr: got %0d writes / last addr mismatch, want last addr 199", wq.size());
        end
    endtask

    task automatic test_overflow();
        int bad, x, y;
        do_reset();
        start_frame(1'b0, 16'd640, 16'd480);
        for (int n = 0; n < 257; n++) send_pixel(n);
        n_checks++;
        if (overflow_err !== 1'b1 || space_ok !== 1'b0 || protocol_err !== 1'b0) begin
            n_fail++;
            $display("FAIL overflow_flags: got ov=%b space_ok=%b pe=%b, want 1/0/0", overflow_err, space_ok, protocol_err);
        end
        repeat (43) tick();
        n_checks++;
        if (wr_valid !== 1'b1 || wr_addr !== '0 || wr_data !== exp_data(pix(0))) begin
            n_fail++;
            $display("FAIL overflow_hold: got wv=%b addr=%h data=%h, want 1/0/%h", wr_valid, wr_addr, wr_data, exp_data(pix(0)));
        end
        wr_ready = 1'b1;
        repeat (300) tick();
        n_checks++;
        if (wq.size() != 256) begin
            n_fail++;
            $display("FAIL overflow_retained: got %0d writes, want 256", wq.size());
        end
        bad = 0;
        for (int i = 0; i < wq.size() && i < 256; i++) begin
            x = (i / 64) * 8 + (i % 8);
            y = (i % 64) / 8;
            if (wq[i] !== {ADDR_W'(y * 640 + x), exp_data(pix(i))}) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL overflow_entries: got %0d bad entries, want 0", bad);
        end
    endtask

    task automatic test_random_stall();
        int n, bad;
        bit stalled;
        logic [ADDR_W-1:0] s_addr;
        logic [23:0] s_data;
        do_reset();
        start_frame(1'b0, 16'd8, 16'd8);
        n = 0;
        for (int cyc = 0; cyc < 2000 && fd_cnt == 0; cyc++) begin
            if (n < 64) begin
                {r_in, g_in, b_in} = pix(n + 500);
                pixel_valid = 1'b1;
                n++;
            end else begin
                pixel_valid = 1'b0;
            end
            wr_ready = 1'($urandom_range(0, 1));
            stalled = wr_valid && !wr_ready;
            s_addr = wr_addr;
            s_data = wr_data;
            tick();
            if (stalled) begin
                n_checks++;
                if (wr_valid !== 1'b1 || wr_addr !== s_addr || wr_data !== s_data) begin
                    n_fail++;
                    $display("FAIL stall_stable: got wv=%b addr=%h data=%h, want 1/%h/%h", wr_valid, wr_addr, wr_data, s_addr, s_data);
                end
            end
        end
        pixel_valid = 1'b0;
        n_checks++;
        if (fd_cnt != 1 || wq.size() != 64) begin
            n_fail++;
            $display("FAIL stall_count: got %0d writes %0d done pulses, want 64/1", wq.size(), fd_cnt);
        end
        bad = 0;
        for (int i = 0; i < wq.size() && i < 64; i++)
            if (wq[i] !== {ADDR_W'(i), exp_data(pix(i + 500))}) bad++;
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL stall_order: got %0d bad entries, want 0", bad);
        end
    endtask

    task automatic test_restart();
        bit ok;
        int bad;
        do_reset();
        start_frame(1'b0, 16'd8, 16'd8);
        for (int n = 0; n < 30; n++) send_pixel(n + 1000);
        start_frame(1'b0, 16'd8, 16'd8);
        n_checks++;
        if (wr_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL restart_flush: got wv=%b, want 0", wr_valid);
        end
        wr_ready = 1'b1;
        for (int n = 0; n < 64; n++) send_pixel(n + 2000);
        wait_frame(200, ok);
        n_checks++;
        if (!ok || fd_cnt != 1 || wq.size() != 64) begin
            n_fail++;
            $display("FAIL restart_count: got %0d writes %0d done pulses, want 64/1", wq.size(), fd_cnt);
        end
        bad = 0;
        for (int i = 0; i < wq.size() && i < 64; i++)
            if (wq[i] !== {ADDR_W'(i), exp_data(pix(i + 2000))}) bad++;
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL restart_entries: got %0d bad entries, want 0", bad);
        end
    endtask

    task automatic test_drain_reset();
        do_reset();
        start_frame(1'b0, 16'd8, 16'd8);
        for (int n = 0; n < 64; n++) send_pixel(n);
        repeat (2) tick();
        n_checks++;
        if (wr_valid !== 1'b1 || space_ok !== 1'b1) begin
            n_fail++;
            $display("FAIL drain_pending: got wv=%b space_ok=%b, want 1/1", wr_valid, space_ok);
        end
        rst_n = 1'b0;
        tick();
        n_checks++;
        if (wr_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL drain_reset: got wv=%b, want 0", wr_valid);
        end
        rst_n = 1'b1;
        wr_ready = 1'b1;
        repeat (10) tick();
        n_checks++;
        if (wq.size() != 0 || fd_cnt != 0 || protocol_err !== 1'b0) begin
            n_fail++;
            $display("FAIL drain_discard: got %0d writes %0d done pe=%b, want 0/0/0", wq.size(), fd_cnt, protocol_err);
        end
    endtask

    initial begin
        test_reset();
        test_protocol();
        test_444_frame();
        test_420_clip();
        test_overflow();
        test_random_stall();
        test_restart();
        test_drain_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
